// File: rtl/register_file_mp_pkg.sv
// Shared constants for the multi-ported register file and its busy scoreboard.
package register_file_mp_pkg;

   localparam int unsigned RF_ADDR_LEN_DEF = 5;
   localparam int unsigned RF_DATA_LEN_DEF = 32;
   localparam int unsigned REG_ZERO        = 0;

endpackage

// File: rtl/register_file_mp_rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking an in-flight producer.
module rf_scoreboard
   import register_file_mp_pkg::*;
#(
   parameter int unsigned RF_ADDR_LEN  = RF_ADDR_LEN_DEF,
   parameter int unsigned NUM_RD_PORTS = 2,
   parameter int unsigned NUM_WR_PORTS = 2,
   parameter int unsigned ZERO_REG_EN  = 1,
   parameter int unsigned BYPASS_EN    = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_RD_PORTS*RF_ADDR_LEN-1:0] rs_addr,
   output logic [NUM_RD_PORTS-1:0]             rs_busy,
   input  logic [NUM_WR_PORTS-1:0]             w_en,
   input  logic [NUM_WR_PORTS*RF_ADDR_LEN-1:0] rd_addr,
   input  logic                                busy_set_en,
   input  logic [RF_ADDR_LEN-1:0]              busy_set_addr
);

   localparam int unsigned DEPTH = 2 ** RF_ADDR_LEN;
   localparam logic [RF_ADDR_LEN-1:0] ZERO_ADDR = RF_ADDR_LEN'(REG_ZERO);

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_next;

   // Set is applied after clears so a new producer supersedes a retiring one.
   always_comb begin
      busy_next = busy;
      for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
         if (w_en[k]) busy_next[rd_addr[k*RF_ADDR_LEN +: RF_ADDR_LEN]] = 1'b0;
      end
      if (busy_set_en) busy_next[busy_set_addr] = 1'b1;
      if (ZERO_REG_EN != 0) busy_next[ZERO_ADDR] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy <= '0;
      else      busy <= busy_next;
   end

   for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
      logic [RF_ADDR_LEN-1:0] a;
      logic                   b;
      assign a = rs_addr[i*RF_ADDR_LEN +: RF_ADDR_LEN];
      always_comb begin
         b = busy[a];
         for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
            if (BYPASS_EN != 0 && w_en[k] && rd_addr[k*RF_ADDR_LEN +: RF_ADDR_LEN] == a) b = 1'b0;
         end
         if ((ZERO_REG_EN != 0 && a == ZERO_ADDR) || !rst) b = 1'b0;
      end
      assign rs_busy[i] = b;
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-ported register file: combinational reads with optional bypass,
// synchronous writes (higher port index wins), optional hardwired zero register.
module register_file_mp
   import register_file_mp_pkg::*;
#(
   parameter int unsigned RF_ADDR_LEN  = RF_ADDR_LEN_DEF,
   parameter int unsigned RF_DATA_LEN  = RF_DATA_LEN_DEF,
   parameter int unsigned NUM_RD_PORTS = 2,
   parameter int unsigned NUM_WR_PORTS = 2,
   parameter int unsigned ZERO_REG_EN  = 1,
   parameter int unsigned BYPASS_EN    = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_RD_PORTS*RF_ADDR_LEN-1:0] rs_addr,
   output logic [NUM_RD_PORTS*RF_DATA_LEN-1:0] rs_data,
   output logic [NUM_RD_PORTS-1:0]             rs_busy,
   input  logic [NUM_WR_PORTS-1:0]             w_en,
   input  logic [NUM_WR_PORTS*RF_ADDR_LEN-1:0] rd_addr,
   input  logic [NUM_WR_PORTS*RF_DATA_LEN-1:0] rd_write_data,
   input  logic                                busy_set_en,
   input  logic [RF_ADDR_LEN-1:0]              busy_set_addr
);

   localparam int unsigned DEPTH = 2 ** RF_ADDR_LEN;
   localparam logic [RF_ADDR_LEN-1:0] ZERO_ADDR = RF_ADDR_LEN'(REG_ZERO);

   logic [RF_DATA_LEN-1:0] regs [DEPTH];

   // Ports are applied in ascending order so the highest-index writer lands last.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
            if (w_en[k] && !(ZERO_REG_EN != 0 && rd_addr[k*RF_ADDR_LEN +: RF_ADDR_LEN] == ZERO_ADDR))
               regs[rd_addr[k*RF_ADDR_LEN +: RF_ADDR_LEN]] <= rd_write_data[k*RF_DATA_LEN +: RF_DATA_LEN];
         end
      end
   end

   for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
      logic [RF_ADDR_LEN-1:0] a;
      logic [RF_DATA_LEN-1:0] d;
      assign a = rs_addr[i*RF_ADDR_LEN +: RF_ADDR_LEN];
      always_comb begin
         d = regs[a];
         for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
            if (BYPASS_EN != 0 && w_en[k] && rd_addr[k*RF_ADDR_LEN +: RF_ADDR_LEN] == a)
               d = rd_write_data[k*RF_DATA_LEN +: RF_DATA_LEN];
         end
         if ((ZERO_REG_EN != 0 && a == ZERO_ADDR) || !rst) d = '0;
      end
      assign rs_data[i*RF_DATA_LEN +: RF_DATA_LEN] = d;
   end

   rf_scoreboard #(
      .RF_ADDR_LEN  (RF_ADDR_LEN),
      .NUM_RD_PORTS (NUM_RD_PORTS),
      .NUM_WR_PORTS (NUM_WR_PORTS),
      .ZERO_REG_EN  (ZERO_REG_EN),
      .BYPASS_EN    (BYPASS_EN)
   ) u_scoreboard (
      .clk           (clk),
      .rst           (rst),
      .rs_addr       (rs_addr),
      .rs_busy       (rs_busy),
      .w_en          (w_en),
      .rd_addr       (rd_addr),
      .busy_set_en   (busy_set_en),
      .busy_set_addr (busy_set_addr)
   );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: default configuration plus a 4-read/1-write no-bypass variant.
module tb_register_file_mp;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [9:0]  a_rs_addr;
   logic [63:0] a_rs_data;
   logic [1:0]  a_rs_busy;
   logic [1:0]  a_w_en;
   logic [9:0]  a_rd_addr;
   logic [63:0] a_wd;
   logic        a_set_en;
   logic [4:0]  a_set_addr;

   logic [19:0]  b_rs_addr;
   logic [127:0] b_rs_data;
   logic [3:0]   b_rs_busy;
   logic [0:0]   b_w_en;
   logic [4:0]   b_rd_addr;
   logic [31:0]  b_wd;
   logic         b_set_en;
   logic [4:0]   b_set_addr;

   int n_cmp = 0;
   int n_bad = 0;

   register_file_mp dut_a (
      .clk (clk), .rst (rst),
      .rs_addr (a_rs_addr), .rs_data (a_rs_data), .rs_busy (a_rs_busy),
      .w_en (a_w_en), .rd_addr (a_rd_addr), .rd_write_data (a_wd),
      .busy_set_en (a_set_en), .busy_set_addr (a_set_addr)
   );

   register_file_mp #(
      .NUM_RD_PORTS (4),
      .NUM_WR_PORTS (1),
      .BYPASS_EN    (0)
   ) dut_b (
      .clk (clk), .rst (rst),
      .rs_addr (b_rs_addr), .rs_data (b_rs_data), .rs_busy (b_rs_busy),
      .w_en (b_w_en), .rd_addr (b_rd_addr), .rd_write_data (b_wd),
      .busy_set_en (b_set_en), .busy_set_addr (b_set_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_rs_addr = '0; a_w_en = '0; a_rd_addr = '0; a_wd = '0; a_set_en = 1'b0; a_set_addr = '0;
      b_rs_addr = '0; b_w_en = '0; b_rd_addr = '0; b_wd = '0; b_set_en = 1'b0; b_set_addr = '0;

      // reset state
      #2;
      a_rs_addr = {5'd3, 5'd8};
      #1;
      chk("rst_data0", a_rs_data[31:0], 32'h0);
      chk("rst_busy", {30'd0, a_rs_busy}, 32'h0);
      tick();
      rst = 1'b1;
      tick();

      // write r8 = A5 with bypass, mark r8 busy, then async reset mid-cycle
      a_w_en = 2'b01; a_rd_addr = {5'd0, 5'd8}; a_wd = {32'd0, 32'hA5};
      #1;
      chk("byp_a5", a_rs_data[31:0], 32'hA5);
      tick();
      a_w_en = 2'b00; a_set_en = 1'b1; a_set_addr = 5'd8;
      #1;
      chk("rd_a5", a_rs_data[31:0], 32'hA5);
      tick();
      a_set_en = 1'b0;
      #1;
      chk("busy_r8", {31'd0, a_rs_busy[0]}, 32'h1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_data", a_rs_data[31:0], 32'h0);
      chk("async_rst_busy", {31'd0, a_rs_busy[0]}, 32'h0);
      a_w_en = 2'b01; a_wd = {32'd0, 32'h55};
      #1;
      chk("rst_byp_gated", a_rs_data[31:0], 32'h0);
      tick();
      a_w_en = 2'b00;
      #2;
      rst = 1'b1;
      tick();
      chk("post_rst_r8", a_rs_data[31:0], 32'h0);

      // bypass on both read ports, then registered read
      a_w_en = 2'b01; a_rd_addr = {5'd0, 5'd8}; a_wd = {32'd0, 32'd24}; a_rs_addr = {5'd8, 5'd8};
      #1;
      chk("byp24_p0", a_rs_data[31:0], 32'd24);
      chk("byp24_p1", a_rs_data[63:32], 32'd24);
      tick();
      a_w_en = 2'b00;
      #1;
      chk("rd24", a_rs_data[31:0], 32'd24);

      // zero register ignores writes and busy sets
      a_w_en = 2'b10; a_rd_addr = {5'd0, 5'd0}; a_wd = {32'h3, 32'd0}; a_rs_addr = {5'd8, 5'd0};
      a_set_en = 1'b1; a_set_addr = 5'd0;
      #1;
      chk("r0_during", a_rs_data[31:0], 32'h0);
      tick();
      a_w_en = 2'b00; a_set_en = 1'b0;
      #1;
      chk("r0_after", a_rs_data[31:0], 32'h0);
      chk("r0_busy", {31'd0, a_rs_busy[0]}, 32'h0);

      // write-write conflict: port1 wins
      a_w_en = 2'b11; a_rd_addr = {5'd9, 5'd9}; a_wd = {32'd99, 32'd27}; a_rs_addr = {5'd1, 5'd9};
      #1;
      chk("conf_byp", a_rs_data[31:0], 32'd99);
      tick();
      a_w_en = 2'b00;
      #1;
      chk("conf_rd", a_rs_data[31:0], 32'd99);
      a_w_en = 2'b11; a_rd_addr = {5'd9, 5'd1}; a_wd = {32'd5, 32'd3}; a_rs_addr = {5'd9, 5'd1};
      #1;
      chk("dual_byp_r1", a_rs_data[31:0], 32'd3);
      chk("dual_byp_r9", a_rs_data[63:32], 32'd5);
      tick();
      a_w_en = 2'b00;
      #1;
      chk("dual_rd_r1", a_rs_data[31:0], 32'd3);
      chk("dual_rd_r9", a_rs_data[63:32], 32'd5);

      // scoreboard set / clear / set-wins
      a_rs_addr = {5'd5, 5'd5}; a_set_en = 1'b1; a_set_addr = 5'd5;
      #1;
      chk("sb_not_yet", {30'd0, a_rs_busy}, 32'h0);
      tick();
      a_set_en = 1'b0;
      #1;
      chk("sb_set", {30'd0, a_rs_busy}, 32'h3);
      a_w_en = 2'b01; a_rd_addr = {5'd0, 5'd5}; a_wd = {32'd0, 32'd7};
      #1;
      chk("sb_fwd_busy", {30'd0, a_rs_busy}, 32'h0);
      chk("sb_fwd_data", a_rs_data[31:0], 32'd7);
      tick();
      a_w_en = 2'b00;
      #1;
      chk("sb_clear", {30'd0, a_rs_busy}, 32'h0);
      a_set_en = 1'b1; a_set_addr = 5'd5; a_w_en = 2'b10; a_rd_addr = {5'd5, 5'd0}; a_wd = {32'd7, 32'd0};
      tick();
      a_set_en = 1'b0; a_w_en = 2'b00;
      #1;
      chk("sb_setwins_busy", {31'd0, a_rs_busy[0]}, 32'h1);
      chk("sb_setwins_data", a_rs_data[31:0], 32'd7);

      // four read ports, one write port, no bypass
      b_rs_addr = {5'd3, 5'd3, 5'd3, 5'd3}; b_w_en = 1'b1; b_rd_addr = 5'd3; b_wd = 32'd11;
      #1;
      for (int p = 0; p < 4; p++) chk($sformatf("nobyp_old_p%0d", p), b_rs_data[p*32 +: 32], 32'd0);
      tick();
      b_w_en = 1'b0;
      #1;
      for (int p = 0; p < 4; p++) chk($sformatf("nobyp_new_p%0d", p), b_rs_data[p*32 +: 32], 32'd11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
